// File: rtl/sa_out_drain.sv
// sa_out_drain
//   Drains the bottom edge of a systolic array. Column c produces its result
//   c cycles after column 0. A per-column deskew pipe realigns the columns
//   into one row, and the aligned rows are queued in a small FIFO for a
//   ready/valid consumer.
//
// Ports
//   DR_clk        sole clock, rising edge
//   DR_rst_n      asynchronous active-low reset
//   DR_clr        synchronous flush of deskew valids, FIFO and overflow flag
//   DR_in_valid   column 0 result valid (column c follows c cycles later)
//   DR_in_data    column results, column c at [c*DATA_WIDTH +: DATA_WIDTH]
//   DR_out_valid  FIFO head holds an aligned row
//   DR_out_ready  consumer accepts the head row
//   DR_out_data   aligned row, same packing as DR_in_data
//   DR_count      FIFO occupancy
//   DR_overflow   sticky: an aligned row was dropped because the FIFO was full
module sa_out_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int N_COLS     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              DR_clk,
  input  logic                              DR_rst_n,
  input  logic                              DR_clr,
  input  logic                              DR_in_valid,
  input  logic [N_COLS*DATA_WIDTH-1:0]      DR_in_data,
  output logic                              DR_out_valid,
  input  logic                              DR_out_ready,
  output logic [N_COLS*DATA_WIDTH-1:0]      DR_out_data,
  output logic [$clog2(FIFO_DEPTH):0]       DR_count,
  output logic                              DR_overflow
);

  localparam int RW = N_COLS * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int VS = N_COLS - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Valid shift register; its last stage marks the cycle in which every
  // column of a row is present at the deskew outputs.
  logic [VS-1:0] vld_sr_q, vld_sr_d;
  logic          row_valid;
  logic [RW-1:0] row_data;

  always_comb begin
    vld_sr_d = (vld_sr_q << 1) | VS'(DR_in_valid);
    if (DR_clr) vld_sr_d = '0;
  end

  always_ff @(posedge DR_clk or negedge DR_rst_n) begin
    if (!DR_rst_n) vld_sr_q <= '0;
    else           vld_sr_q <= vld_sr_d;
  end

  assign row_valid = vld_sr_q[VS-1];

  // Deskew: column c sits behind N_COLS-1-c free-running registers; the last
  // column is used straight from the input.
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    if (c == N_COLS - 1) begin : g_direct
      assign row_data[c*DATA_WIDTH +: DATA_WIDTH] = DR_in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      localparam int D = N_COLS - 1 - c;
      logic signed [DATA_WIDTH-1:0] sr_q [D];
      logic signed [DATA_WIDTH-1:0] sr_d [D];

      always_comb begin
        sr_d[0] = DR_in_data[c*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 1; k < D; k++) sr_d[k] = sr_q[k-1];
      end

      always_ff @(posedge DR_clk or negedge DR_rst_n) begin
        if (!DR_rst_n) begin
          for (int k = 0; k < D; k++) sr_q[k] <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end

      assign row_data[c*DATA_WIDTH +: DATA_WIDTH] = sr_q[D-1];
    end
  end

  // Aligned-row FIFO. Occupancy is tracked explicitly so full and empty never
  // depend on pointer equality.
  logic [RW-1:0] mem_q [FIFO_DEPTH];
  logic [RW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop, push_ok;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    pop     = (count_q != '0) && DR_out_ready;
    // A full FIFO still takes a row when the head leaves on the same edge.
    push_ok = row_valid && ((count_q != DEPTH_C) || pop);

    if (DR_clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = row_data;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push_ok) count_d = count_q - CW'(1);
      if (row_valid && !push_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge DR_clk or negedge DR_rst_n) begin
    if (!DR_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign DR_out_valid = (count_q != '0);
  assign DR_out_data  = mem_q[rptr_q];
  assign DR_count     = count_q;
  assign DR_overflow  = ovf_q;

endmodule

// File: tb/tb_sa_out_drain.sv
// tb_sa_out_drain
//   Self-checking bench for sa_out_drain (DATA_WIDTH=32, N_COLS=4,
//   FIFO_DEPTH=4). Rows are described as whole rows with a start cycle; the
//   reference model is a queue of rows that a row joins 3 edges after its
//   start, with drop/overflow when the queue is full and not popping.
module tb_sa_out_drain;

  localparam int NC  = 4;
  localparam int DW  = 32;
  localparam int RW  = NC * DW;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst_n, clr, in_valid, out_valid, out_ready, ovf;
  logic [RW-1:0] in_data, out_data;
  logic [2:0]    count;

  sa_out_drain #(.DATA_WIDTH(DW), .N_COLS(NC), .FIFO_DEPTH(4)) dut (
    .DR_clk(clk), .DR_rst_n(rst_n), .DR_clr(clr), .DR_in_valid(in_valid),
    .DR_in_data(in_data), .DR_out_valid(out_valid), .DR_out_ready(out_ready),
    .DR_out_data(out_data), .DR_count(count), .DR_overflow(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit            started [MAXC];
  bit            live    [MAXC];
  logic [RW-1:0] rv      [MAXC];
  logic [RW-1:0] q [$];
  bit            m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rrow();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_outputs();
    chk("valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("ovf", ovf, m_ovf);
    if (q.size() != 0) chk("data", out_data, q[0]);
  endtask

  // One clock cycle: apply inputs, clock, advance the model, check outputs.
  task automatic drive_cycle(input bit st, input logic [RW-1:0] row, input bit rdy, input bit cl);
    int  s;
    bit  pop, push;
    started[cyc] = st;
    rv[cyc]      = row;
    live[cyc]    = st;
    for (int c = 0; c < NC; c++) begin
      s = cyc - c;
      in_data[c*DW +: DW] = $urandom;
      if (s >= 0) begin
        if (started[s]) in_data[c*DW +: DW] = rv[s][c*DW +: DW];
      end
    end
    in_valid  = st;
    out_ready = rdy;
    clr       = cl;
    @(posedge clk);
    if (cl) begin
      q.delete();
      m_ovf = 1'b0;
      for (int k = 0; k <= cyc; k++) live[k] = 1'b0;
    end else begin
      pop  = (q.size() != 0) && rdy;
      push = 1'b0;
      if (cyc >= NC - 1) push = live[cyc-(NC-1)];
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < 4) q.push_back(rv[cyc-(NC-1)]);
        else              m_ovf = 1'b1;
      end
    end
    #1;
    check_outputs();
    cyc++;
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_ovf", ovf, 1'b0);
    q.delete();
    m_ovf = 1'b0;
    for (int k = 0; k <= cyc; k++) live[k] = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_count", count, 3'd0);
    chk("reset_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    // Single row, always ready
    drive_cycle(1'b1, {32'h13, 32'h12, 32'h11, 32'h10}, 1'b1, 1'b0);
    repeat (6) drive_cycle(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: five back-to-back rows, fifth dropped, then drain
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, rrow(), 1'b0, 1'b0);
    repeat (4) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (6) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b1);

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, rrow(), 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, rrow(), 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (2) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (6) drive_cycle(1'b0, '0, 1'b1, 1'b0);

    // Signed extremes pass through bit-exact
    drive_cycle(1'b1, {32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000}, 1'b1, 1'b0);
    repeat (5) drive_cycle(1'b0, '0, 1'b1, 1'b0);

    // Clear with two rows buffered and one still in the deskew pipe
    drive_cycle(1'b1, rrow(), 1'b0, 1'b0);
    drive_cycle(1'b1, rrow(), 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, rrow(), 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (6) drive_cycle(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic with occasional clears
    repeat (1500) drive_cycle(bit'($urandom_range(0, 1)), rrow(),
                              $urandom_range(0, 4) < 3, $urandom_range(0, 99) == 0);
    drive_cycle(1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, rrow(), 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    async_reset_pulse();
    drive_cycle(1'b1, rrow(), 1'b1, 1'b0);
    repeat (5) drive_cycle(1'b0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
